// File: rtl/bd2003_pkg.sv
// Shared constants and state encoding for the BANDAI2003 unlock host.
package bd2003_pkg;

    localparam logic [7:0] ADDR_ACK   = 8'h5A;
    localparam logic [7:0] ADDR_NAK   = 8'hA5;
    localparam logic [7:0] ADDR_NIH   = 8'hFF;
    localparam logic [7:0] ADDR_LAO   = 8'hC0;
    localparam logic [7:0] ADDR_BRAM  = 8'hC1;
    localparam logic [7:0] ADDR_BROM0 = 8'hC2;
    localparam logic [7:0] ADDR_BROM1 = 8'hC3;

    localparam int FRAME_LEN   = 18;
    localparam int PAYLOAD_LEN = FRAME_LEN - 2;

    typedef enum logic [3:0] {
        S_IDLE, S_ACKA, S_NAKA, S_HUNT, S_SHIFT, S_STOP,
        S_READY, S_FAIL, S_RSET, S_RSTB, S_RHLD
    } state_t;

    function automatic logic [7:0] reg_addr(input logic [1:0] idx);
        logic [7:0] a;
        unique case (idx)
            2'd0:    a = ADDR_LAO;
            2'd1:    a = ADDR_BRAM;
            2'd2:    a = ADDR_BROM0;
            default: a = ADDR_BROM1;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/bd2003_serial_rx.sv
// Acknowledge frame receiver: hunts for the start bit, shifts the
// payload LSB first and judges the stop bit and payload value.
module bd2003_serial_rx
    import bd2003_pkg::*;
#(
    parameter int          TIMEOUT = 32,
    parameter logic [15:0] EXPECT  = 16'h28A0
) (
    input  logic        CLK,
    input  logic        RSTn,
    input  logic        arm,
    input  logic        SI,
    output logic        done,
    output logic        ok,
    output logic        timeout,
    output logic [15:0] code
);

    localparam logic [5:0] HUNT_LAST = 6'(TIMEOUT - 1);
    localparam logic [3:0] BIT_LAST  = 4'(PAYLOAD_LEN - 1);

    state_t      st, nst;
    logic [5:0]  hcnt;
    logic [3:0]  bcnt;
    logic [15:0] shreg;

    always_comb begin
        nst     = st;
        done    = 1'b0;
        ok      = 1'b0;
        timeout = 1'b0;
        unique case (st)
            S_HUNT: begin
                if (!SI) begin
                    nst = S_SHIFT;
                end else if (hcnt == HUNT_LAST) begin
                    timeout = 1'b1;
                    nst     = S_IDLE;
                end
            end
            S_SHIFT: if (bcnt == BIT_LAST) nst = S_STOP;
            S_STOP: begin
                done = 1'b1;
                ok   = !SI && (shreg == EXPECT);
                nst  = S_IDLE;
            end
            default: if (arm) nst = S_HUNT;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            st    <= S_IDLE;
            hcnt  <= '0;
            bcnt  <= '0;
            shreg <= '0;
            code  <= '0;
        end else begin
            st <= nst;
            unique case (st)
                S_HUNT:  if (hcnt != 6'h3F) hcnt <= hcnt + 6'd1;
                S_SHIFT: begin
                    shreg <= {SI, shreg[15:1]};
                    bcnt  <= bcnt + 4'd1;
                end
                S_STOP:  code <= shreg;
                default: begin
                    hcnt <= '0;
                    bcnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/bd2003_unlock_host.sv
// Console-side BANDAI2003 initiator: unlock handshake, acknowledge
// check, then three-cycle bank-register bus cycles.
module bd2003_unlock_host
    import bd2003_pkg::*;
#(
    parameter int          TIMEOUT = 32,
    parameter logic [15:0] EXPECT  = 16'h28A0
) (
    input  logic        CLK,
    input  logic        RSTn,
    input  logic        START,
    input  logic        SI,
    input  logic        REQ,
    input  logic        WE,
    input  logic [1:0]  IDX,
    input  logic [7:0]  WDATA,
    input  logic [7:0]  DQ_I,
    output logic [7:0]  ADDR,
    output logic        CEn,
    output logic        SSn,
    output logic        WEn,
    output logic        OEn,
    output logic [7:0]  DQ_O,
    output logic        DQ_OE,
    output logic        BUSY,
    output logic        UNLOCKED,
    output logic        FAIL,
    output logic [15:0] CODE,
    output logic        ACK,
    output logic [7:0]  RDATA
);

    state_t     state, nstate;
    logic       rx_arm, rx_done, rx_ok, rx_to;
    logic       we_q, n_we;
    logic [7:0] n_addr, n_dqo;
    logic       n_ssn, n_wen, n_oen, n_dqoe, n_ack;

    assign rx_arm = (state == S_NAKA);

    bd2003_serial_rx #(
        .TIMEOUT (TIMEOUT),
        .EXPECT  (EXPECT)
    ) u_rx (
        .CLK     (CLK),
        .RSTn    (RSTn),
        .arm     (rx_arm),
        .SI      (SI),
        .done    (rx_done),
        .ok      (rx_ok),
        .timeout (rx_to),
        .code    (CODE)
    );

    always_ff @(posedge CLK) begin
        if (!RSTn) state <= S_IDLE;
        else       state <= nstate;
    end

    always_comb begin
        nstate = state;
        n_addr = ADDR_NIH;
        n_ssn  = 1'b1;
        n_wen  = 1'b1;
        n_oen  = 1'b1;
        n_dqo  = '0;
        n_dqoe = 1'b0;
        n_ack  = 1'b0;
        n_we   = we_q;
        unique case (state)
            S_IDLE, S_FAIL: begin
                if (START) begin
                    nstate = S_ACKA;
                    n_addr = ADDR_ACK;
                end
            end
            S_ACKA: begin
                nstate = S_NAKA;
                n_addr = ADDR_NAK;
            end
            S_NAKA: nstate = S_HUNT;
            S_HUNT: begin
                if (rx_to || (rx_done && !rx_ok)) nstate = S_FAIL;
                else if (rx_done)                 nstate = S_READY;
            end
            S_READY: begin
                if (REQ) begin
                    nstate = S_RSET;
                    n_we   = WE;
                    n_addr = reg_addr(IDX);
                    n_ssn  = 1'b0;
                    n_dqoe = WE;
                    n_dqo  = WE ? WDATA : '0;
                end
            end
            S_RSET, S_RSTB: begin
                nstate = (state == S_RSET) ? S_RSTB : S_RHLD;
                n_addr = ADDR;
                n_ssn  = 1'b0;
                n_dqoe = DQ_OE;
                n_dqo  = DQ_O;
                // strobe only during RSTB; RHLD releases it and acks
                n_wen  = (state == S_RSET) ? !we_q : 1'b1;
                n_oen  = (state == S_RSET) ? we_q : 1'b1;
                n_ack  = (state == S_RSTB);
            end
            S_RHLD:  nstate = S_READY;
            default: nstate = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            ADDR     <= ADDR_NIH;
            CEn      <= 1'b1;
            SSn      <= 1'b1;
            WEn      <= 1'b1;
            OEn      <= 1'b1;
            DQ_O     <= '0;
            DQ_OE    <= 1'b0;
            BUSY     <= 1'b0;
            UNLOCKED <= 1'b0;
            FAIL     <= 1'b0;
            ACK      <= 1'b0;
            RDATA    <= '0;
            we_q     <= 1'b0;
        end else begin
            ADDR     <= n_addr;
            CEn      <= 1'b1;
            SSn      <= n_ssn;
            WEn      <= n_wen;
            OEn      <= n_oen;
            DQ_O     <= n_dqo;
            DQ_OE    <= n_dqoe;
            ACK      <= n_ack;
            we_q     <= n_we;
            BUSY     <= nstate inside {S_ACKA, S_NAKA, S_HUNT,
                                       S_RSET, S_RSTB, S_RHLD};
            UNLOCKED <= nstate inside {S_READY, S_RSET, S_RSTB, S_RHLD};
            FAIL     <= (nstate == S_FAIL);
            if (state == S_RSTB && !we_q) RDATA <= DQ_I;
        end
    end

endmodule

// File: tb/tb_bd2003_unlock_host.sv
// Scoreboard bench for bd2003_unlock_host: stimulus queues expected
// per-cycle outputs and ACK data; monitors pop and compare.
module tb_bd2003_unlock_host;

    logic        CLK = 1'b0;
    logic        RSTn, START, SI, REQ, WE;
    logic [1:0]  IDX;
    logic [7:0]  WDATA, DQ_I;
    logic [7:0]  ADDR, DQ_O, RDATA;
    logic        CEn, SSn, WEn, OEn, DQ_OE;
    logic        BUSY, UNLOCKED, FAIL, ACK;
    logic [15:0] CODE;

    bd2003_unlock_host dut (
        .CLK(CLK), .RSTn(RSTn), .START(START), .SI(SI),
        .REQ(REQ), .WE(WE), .IDX(IDX), .WDATA(WDATA),
        .DQ_I(DQ_I), .ADDR(ADDR), .CEn(CEn), .SSn(SSn),
        .WEn(WEn), .OEn(OEn), .DQ_O(DQ_O), .DQ_OE(DQ_OE),
        .BUSY(BUSY), .UNLOCKED(UNLOCKED), .FAIL(FAIL),
        .CODE(CODE), .ACK(ACK), .RDATA(RDATA)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [7:0]  addr;
        logic        cen, ssn, wen, oen;
        logic [7:0]  dqo;
        logic        dqoe, busy, unl, fail, ack;
        logic [15:0] code;
        logic [7:0]  rdata;
    } obs_t;

    typedef struct {
        int    at;
        string nm;
        obs_t  e;
        obs_t  m;
    } exp_t;

    exp_t q[$];
    int   ackq[$];
    int   cyc = 0;
    int   nvec = 0;
    int   nbad = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic want(input int at, input string nm,
                        input obs_t e, input obs_t m);
        exp_t x;
        x.at = at; x.nm = nm; x.e = e; x.m = m;
        q.push_back(x);
    endtask

    task automatic w_reset(input int at, input string nm);
        obs_t e, m;
        e = '0; m = '1;
        e.addr = 8'hFF;
        e.cen = 1'b1; e.ssn = 1'b1; e.wen = 1'b1; e.oen = 1'b1;
        want(at, nm, e, m);
    endtask

    task automatic w_addr(input int at, input string nm,
                          input logic [7:0] a);
        obs_t e, m;
        e = '0; m = '0;
        e.addr = a; m.addr = '1;
        want(at, nm, e, m);
    endtask

    task automatic w_flags(input int at, input string nm,
                           input logic busy, input logic unl,
                           input logic fail);
        obs_t e, m;
        e = '0; m = '0;
        e.busy = busy; e.unl = unl; e.fail = fail;
        m.busy = 1'b1; m.unl = 1'b1; m.fail = 1'b1;
        want(at, nm, e, m);
    endtask

    task automatic w_code(input int at, input string nm,
                          input logic [15:0] code, input logic unl,
                          input logic fail);
        obs_t e, m;
        e = '0; m = '0;
        e.code = code; e.unl = unl; e.fail = fail; e.busy = 1'b0;
        m.code = '1; m.unl = 1'b1; m.fail = 1'b1; m.busy = 1'b1;
        want(at, nm, e, m);
    endtask

    task automatic w_bus(input int at, input string nm,
                         input logic [7:0] a, input logic ssn,
                         input logic wen, input logic oen,
                         input logic dqoe, input logic [7:0] dqo,
                         input logic ack);
        obs_t e, m;
        e = '0; m = '0;
        e.addr = a; e.cen = 1'b1; e.ssn = ssn; e.wen = wen;
        e.oen = oen; e.dqoe = dqoe; e.dqo = dqo; e.ack = ack;
        m.addr = '1; m.cen = 1'b1; m.ssn = 1'b1; m.wen = 1'b1;
        m.oen = 1'b1; m.dqoe = 1'b1; m.ack = 1'b1;
        if (dqoe) m.dqo = '1;
        want(at, nm, e, m);
    endtask

    // cycle monitor
    always @(negedge CLK) begin
        obs_t act;
        exp_t x;
        act = {ADDR, CEn, SSn, WEn, OEn, DQ_O, DQ_OE,
               BUSY, UNLOCKED, FAIL, ACK, CODE, RDATA};
        while (q.size() > 0 && q[0].at <= cyc) begin
            x = q.pop_front();
            nvec++;
            if (x.at != cyc) begin
                nbad++;
                $display("FAIL %s: checked at cycle %0d, due %0d",
                         x.nm, cyc, x.at);
            end else if ((act & x.m) !== (x.e & x.m)) begin
                nbad++;
                $display("FAIL %s: cycle %0d got %h want %h mask %h",
                         x.nm, cyc, act, x.e, x.m);
            end
        end
    end

    // ACK monitor
    always @(negedge CLK) begin
        int v;
        if (ACK === 1'b1) begin
            nvec++;
            if (ackq.size() == 0) begin
                nbad++;
                $display("FAIL unexpected_ack: ACK=1 at cycle %0d, none due",
                         cyc);
            end else begin
                v = ackq.pop_front();
                if (v >= 0 && RDATA !== 8'(v)) begin
                    nbad++;
                    $display("FAIL rdata: got %h want %h", RDATA, 8'(v));
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic run_frame(input logic [17:0] fr);
        START = 1'b1;
        tick(1);
        START = 1'b0;
        tick(2);
        for (int i = 0; i < 18; i++) begin
            SI = fr[i];
            tick(1);
        end
        SI = 1'b1;
    endtask

    initial begin
        int b;
        RSTn = 1'b0; START = 1'b0; SI = 1'b1; REQ = 1'b0;
        WE = 1'b0; IDX = '0; WDATA = '0; DQ_I = '0;
        tick(2);
        w_reset(cyc, "reset");
        w_reset(cyc + 1, "reset_idle");
        RSTn = 1'b1;
        tick(2);

        // REQ before unlock
        b = cyc;
        REQ = 1'b1; WE = 1'b1; IDX = 2'd2; WDATA = 8'hAA;
        for (int k = 1; k <= 3; k++)
            w_bus(b + k, "req_locked", 8'hFF, 1, 1, 1, 0, 8'h00, 0);
        tick(3);
        REQ = 1'b0;
        tick(1);

        // SI stuck high: timeout
        b = cyc;
        w_addr(b + 1, "to_acka", 8'h5A);
        w_addr(b + 2, "to_naka", 8'hA5);
        w_flags(b + 34, "to_hunt_last", 1, 0, 0);
        w_flags(b + 35, "to_fail", 0, 0, 1);
        START = 1'b1;
        tick(1);
        START = 1'b0;
        tick(35);

        // restart from FAIL with a good frame
        b = cyc;
        w_addr(b + 1, "ok_acka", 8'h5A);
        w_addr(b + 2, "ok_naka", 8'hA5);
        w_addr(b + 3, "ok_hunt", 8'hFF);
        w_flags(b + 3, "ok_busy", 1, 0, 0);
        w_flags(b + 20, "ok_stop", 1, 0, 0);
        w_code(b + 21, "ok_ready", 16'h28A0, 1, 0);
        run_frame({1'b0, 16'h28A0, 1'b0});

        // write ROM bank 0
        b = cyc;
        REQ = 1'b1; WE = 1'b1; IDX = 2'd2; WDATA = 8'h3C;
        w_bus(b + 1, "wr_rset", 8'hC2, 0, 1, 1, 1, 8'h3C, 0);
        w_bus(b + 2, "wr_rstb", 8'hC2, 0, 0, 1, 1, 8'h3C, 0);
        w_bus(b + 3, "wr_rhld", 8'hC2, 0, 1, 1, 1, 8'h3C, 1);
        w_bus(b + 4, "wr_ready", 8'hFF, 1, 1, 1, 0, 8'h00, 0);
        w_flags(b + 4, "wr_flags", 0, 1, 0);
        ackq.push_back(-1);
        tick(1);
        REQ = 1'b0;
        tick(3);

        // read RAM bank
        b = cyc;
        REQ = 1'b1; WE = 1'b0; IDX = 2'd1; WDATA = 8'hFF;
        w_bus(b + 1, "rd_rset", 8'hC1, 0, 1, 1, 0, 8'h00, 0);
        w_bus(b + 2, "rd_rstb", 8'hC1, 0, 1, 0, 0, 8'h00, 0);
        w_bus(b + 3, "rd_rhld", 8'hC1, 0, 1, 1, 0, 8'h00, 1);
        w_flags(b + 3, "rd_flags", 1, 1, 0);
        ackq.push_back(8'h07);
        tick(1);
        REQ = 1'b0;
        tick(1);
        DQ_I = 8'h07;
        tick(1);
        DQ_I = 8'hEE;
        tick(1);

        // reset during RSTB of a write
        b = cyc;
        REQ = 1'b1; WE = 1'b1; IDX = 2'd0; WDATA = 8'h55;
        w_bus(b + 2, "rw_rstb", 8'hC0, 0, 0, 1, 1, 8'h55, 0);
        w_reset(b + 3, "rw_reset");
        w_addr(b + 5, "rw_stay_addr", 8'hFF);
        w_flags(b + 5, "rw_stay", 0, 0, 0);
        tick(1);
        REQ = 1'b0;
        tick(1);
        RSTn = 1'b0;
        tick(1);
        RSTn = 1'b1;
        tick(3);

        // reset during SHIFT
        b = cyc;
        w_reset(b + 9, "sh_reset");
        w_addr(b + 11, "sh_stay_addr", 8'hFF);
        w_flags(b + 11, "sh_stay", 0, 0, 0);
        START = 1'b1;
        tick(1);
        START = 1'b0;
        tick(2);
        for (int i = 0; i < 5; i++) begin
            SI = (i == 0) ? 1'b0 : 1'b1;
            tick(1);
        end
        RSTn = 1'b0;
        tick(1);
        RSTn = 1'b1;
        SI = 1'b1;
        tick(3);

        // wrong payload
        b = cyc;
        w_flags(b + 20, "bp_stop", 1, 0, 0);
        w_code(b + 21, "bp_fail", 16'h28A1, 0, 1);
        run_frame({1'b0, 16'h28A1, 1'b0});

        // bad stop bit, restarted from FAIL
        b = cyc;
        w_addr(b + 1, "bs_acka", 8'h5A);
        w_code(b + 21, "bs_fail", 16'h28A0, 0, 1);
        run_frame({1'b1, 16'h28A0, 1'b0});
        tick(3);

        nvec++;
        if (q.size() != 0) begin
            nbad++;
            $display("FAIL pending_checks: %0d left, want 0", q.size());
        end
        nvec++;
        if (ackq.size() != 0) begin
            nbad++;
            $display("FAIL missing_ack: %0d ACKs not seen, want 0",
                     ackq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule
